ipv4_tx_encap: RTL and testbench
================================

Name: ipv4_tx_encap

Overview:
IPv4 transmit encapsulator sitting directly below the UDP block. It consumes the UDP block's outgoing byte stream (one UDP datagram per sop..eop), buffers each datagram store-and-forward, and emits it prefixed with a 20-byte IPv4 header. The header carries a computed total length, an identification counter and a header checksum. Its output feeds the Ethernet MAC framing layer.

Parameters:
DEPTH, 4096, payload FIFO depth in bytes (power of 2)
MAX_PAYLOAD, 1480, maximum accepted datagram bytes
LEN_DEPTH, 16, length-FIFO entries (packets in flight)
TTL, 8'd64, IPv4 time-to-live field

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
src_ip  in  32  source address; sampled at header LOAD
dst_ip  in  32  destination address; sampled at header LOAD
din  in  8  UDP byte
din_vld  in  1  byte valid
din_sop  in  1  first byte of datagram (qualified by din_vld)
din_eop  in  1  last byte of datagram (qualified by din_vld)
dout  out  8  IPv4 byte
dout_vld  out  1  byte valid
dout_sop  out  1  first header byte
dout_eop  out  1  last payload byte
status  out  32  {drop_cnt[7:0], runt_cnt[7:0], trunc_cnt[7:0], 5'b0, in_pkt, len_full, data_empty}

Behaviour:
- Reset: all outputs 0, counters 0, ident 0, FSM IDLE, FIFOs empty. Takes effect immediately, mid-packet included; any partial packet is discarded.
- Write side:
  - At sop, admit if free bytes >= MAX_PAYLOAD and the length FIFO is not full. Otherwise drop the whole datagram and increment drop_cnt (saturating).
  - Admitted bytes are written and counted in wr_cnt (11 bits).
  - At eop, push {runt = wr_cnt<8, len = wr_cnt} into the length FIFO.
  - Sop while in_pkt: close the current packet with the count so far (push entry), then start the new packet with the same admission check.
  - Bytes with din_vld but no in_pkt (stray bytes, eop without sop): ignored.
  - wr_cnt reaching MAX_PAYLOAD without eop: push the entry, increment trunc_cnt, ignore bytes until next sop.
- Read FSM:
  - IDLE -> LOAD when the length FIFO is not empty. Pop the entry; latch L, src_ip, dst_ip.
  - LOAD -> CSUM: one cycle.
  - CSUM -> HEAD, or -> DROP if runt.
  - HEAD: 20 bytes, hcnt 0..19, then -> DATA.
  - DATA: pop L bytes, then -> IDLE.
  - DROP: pop L bytes with dout_vld=0, then -> IDLE.
- Header byte order: 45, 00, total_len[15:8], total_len[7:0], ident hi, ident lo, 40 (DF), 00, TTL, 11, csum hi, csum lo, src_ip[31:0] (MSB first), dst_ip[31:0].
- total_len = L + 20, 16 bits.
- Checksum:
  - 20-bit sum of words 4500, total_len, ident, 4000, {TTL,11}, src hi, src lo, dst hi, dst lo.
  - Fold carry twice, then bitwise invert; register in CSUM.
- ident increments (wrapping FFFF->0000) at the end of each transmitted packet; it does not increment on runts.
- dout/dout_vld/dout_sop/dout_eop are registered. Output is contiguous for 20+L cycles; data is guaranteed present (store-and-forward).
- Latency: dout_sop asserts 3 clocks after din_eop is sampled when the FSM is IDLE.
- Minimum gap between packets: 2 idle cycles (LOAD, CSUM).
- Simultaneous write-side push and read-side pop are legal; FIFO occupancy is tracked as +wr -rd.

Decomposition:
- Shared package holds: IPv4 constants (version/IHL 8'h45, PROTO_UDP 8'h11, FLAGS_DF 16'h4000, IP_HDR_LEN 20), the FSM state enum, and the length-entry struct {runt, len[10:0]}.
- Both the payload FIFO (8-bit) and the length FIFO (12-bit) instantiate the existing FIFO_syn. The payload byte counter for admission lives in this block.
- No further sub-modules; the checksum is a local function.

Test Plan:
- Single 12-byte datagram, src C0A8010A, dst C0A80164, TTL 64: expect 32 output bytes 45 00 00 20 00 00 40 00 40 11 B7 0E C0 A8 01 0A C0 A8 01 64, then the 12 payload bytes; sop on the first byte, eop on byte 32.
- Two back-to-back 12-byte datagrams: second header has ident 0001 and checksum B70D; exactly 2 idle cycles between the first eop and the second sop.
- 5-byte datagram followed by a 12-byte one: no output for the first; runt_cnt=1; the following packet carries ident 0000.
- 1500 bytes without eop: output total_len 05DC (1480+20); trunc_cnt=1; trailing 20 bytes ignored.
- Fill the length FIFO (16 pending entries) while holding output, then send a sop: that datagram is dropped; drop_cnt=1; the 16 queued packets emit intact.
- Assert rst during HEAD byte 7: outputs 0 in the same cycle; after release, a new 12-byte datagram emits cleanly with ident 0000.

Source files
------------

// File: rtl/ipv4_tx_encap_pkg.sv
// ============================================================================
// Module : ipv4_tx_encap_pkg
// Brief  : Shared IPv4 constants, read-FSM state encoding, length-FIFO entry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ipv4_tx_encap_pkg;

  localparam logic [7:0]  VER_IHL    = 8'h45;
  localparam logic [7:0]  PROTO_UDP  = 8'h11;
  localparam logic [15:0] FLAGS_DF   = 16'h4000;
  localparam int          IP_HDR_LEN = 20;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CSUM = 3'd2,
    ST_HEAD = 3'd3,
    ST_DATA = 3'd4,
    ST_DROP = 3'd5
  } state_t;

  typedef struct packed {
    logic        runt;
    logic [10:0] len;
  } len_entry_t;

endpackage

`default_nettype wire

// File: rtl/FIFO_syn.sv
// ============================================================================
// Module : FIFO_syn
// Brief  : Single-clock FIFO, registered read data one cycle after rd_en.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module FIFO_syn #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty   = (r_wptr == r_rptr);
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_rd_data;

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= wr_data;
    if (w_rd) r_rd_data <= r_mem[r_rptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ipv4_tx_encap.sv
// ============================================================================
// Module : ipv4_tx_encap
// Brief  : Store-and-forward IPv4 encapsulator prepending a 20-byte header.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ipv4_tx_encap
  import ipv4_tx_encap_pkg::*;
#(
  parameter int         DEPTH       = 4096,
  parameter int         MAX_PAYLOAD = 1480,
  parameter int         LEN_DEPTH   = 16,
  parameter logic [7:0] TTL         = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [7:0]  din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic [31:0] status
);

  localparam int             DAW           = $clog2(DEPTH);
  localparam int             LAW           = $clog2(LEN_DEPTH);
  localparam logic [DAW:0]   C_ADMIT_LIMIT = (DAW+1)'(DEPTH - MAX_PAYLOAD);
  localparam logic [LAW:0]   C_LEN_DEPTH   = (LAW+1)'(LEN_DEPTH);
  localparam logic [10:0]    C_MAX         = 11'(MAX_PAYLOAD);

  function automatic logic [15:0] ip_csum(input logic [15:0] total_len, input logic [15:0] ident,
                                          input logic [31:0] src, input logic [31:0] dst);
    logic [19:0] s;
    s = 20'({VER_IHL, 8'h00}) + 20'(total_len) + 20'(ident) + 20'(FLAGS_DF)
      + 20'({TTL, PROTO_UDP}) + 20'(src[31:16]) + 20'(src[15:0]) + 20'(dst[31:16]) + 20'(dst[15:0]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    return ~s[15:0];
  endfunction

  // Write side
  logic             r_in_pkt;
  logic [10:0]      r_wr_cnt;
  logic [DAW:0]     r_data_cnt;
  logic [LAW:0]     r_len_cnt;
  logic [7:0]       r_drop_cnt, r_runt_cnt, r_trunc_cnt;
  logic             w_sop, w_admit, w_data_wr, w_len_push, w_in_pkt_nxt, w_drop_inc, w_trunc_inc;
  logic [10:0]      w_wr_cnt_nxt, w_wr_cnt_inc, w_push_len;
  logic [LAW:0]     w_len_need;
  len_entry_t       w_len_wdata, w_len_rdata;
  logic             w_len_full, w_len_empty, w_data_full, w_data_empty;
  logic [7:0]       w_data_rdata;

  // Read side
  state_t           r_state, w_state_nxt;
  logic [10:0]      r_cnt, w_cnt_nxt, r_len;
  logic             r_runt;
  logic [31:0]      r_src, r_dst;
  logic [15:0]      r_csum, r_ident, w_total_len;
  logic [7:0]       r_dout, w_dout_nxt, w_hdr_byte;
  logic             r_vld, r_sop, r_eop, w_vld_nxt, w_sop_nxt, w_eop_nxt;
  logic             w_len_pop, w_data_rd, w_data_rd_ok, w_ident_inc, w_runt_inc;

  assign w_sop        = din_vld && din_sop;
  assign w_len_need   = r_len_cnt + {{LAW{1'b0}}, r_in_pkt};
  assign w_admit      = (r_data_cnt <= C_ADMIT_LIMIT) && !w_data_full && (w_len_need < C_LEN_DEPTH);
  assign w_wr_cnt_inc = r_wr_cnt + 11'd1;
  assign w_len_wdata  = '{runt: (w_push_len < 11'd8), len: w_push_len};

  always_comb begin
    w_data_wr    = 1'b0;
    w_len_push   = 1'b0;
    w_push_len   = r_wr_cnt;
    w_in_pkt_nxt = r_in_pkt;
    w_wr_cnt_nxt = r_wr_cnt;
    w_drop_inc   = 1'b0;
    w_trunc_inc  = 1'b0;
    if (w_sop) begin
      w_len_push = r_in_pkt;
      // A one-byte datagram arriving on an open packet would need a second
      // push in the same cycle as the close, so it is dropped instead.
      if (w_admit && !(r_in_pkt && din_eop)) begin
        w_data_wr    = 1'b1;
        w_wr_cnt_nxt = 11'd1;
        w_in_pkt_nxt = !din_eop;
        if (din_eop) begin
          w_len_push = 1'b1;
          w_push_len = 11'd1;
        end
      end else begin
        w_in_pkt_nxt = 1'b0;
        w_wr_cnt_nxt = '0;
        w_drop_inc   = 1'b1;
      end
    end else if (din_vld && r_in_pkt) begin
      w_data_wr    = 1'b1;
      w_wr_cnt_nxt = w_wr_cnt_inc;
      if (din_eop || (w_wr_cnt_inc == C_MAX)) begin
        w_len_push   = 1'b1;
        w_push_len   = w_wr_cnt_inc;
        w_in_pkt_nxt = 1'b0;
        w_trunc_inc  = !din_eop;
      end
    end
  end

  FIFO_syn #(.WIDTH(8), .DEPTH(DEPTH)) u_data_fifo (
    .clk(clk), .rst(rst), .wr_en(w_data_wr), .wr_data(din), .rd_en(w_data_rd),
    .rd_data(w_data_rdata), .full(w_data_full), .empty(w_data_empty)
  );

  FIFO_syn #(.WIDTH(12), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk(clk), .rst(rst), .wr_en(w_len_push), .wr_data(w_len_wdata), .rd_en(w_len_pop),
    .rd_data(w_len_rdata), .full(w_len_full), .empty(w_len_empty)
  );

  assign w_data_rd_ok = w_data_rd && !w_data_empty;
  assign w_total_len  = {5'd0, r_len} + 16'(IP_HDR_LEN);

  always_comb begin
    case (r_cnt[4:0])
      5'd2:    w_hdr_byte = w_total_len[15:8];
      5'd3:    w_hdr_byte = w_total_len[7:0];
      5'd4:    w_hdr_byte = r_ident[15:8];
      5'd5:    w_hdr_byte = r_ident[7:0];
      5'd6:    w_hdr_byte = FLAGS_DF[15:8];
      5'd7:    w_hdr_byte = FLAGS_DF[7:0];
      5'd8:    w_hdr_byte = TTL;
      5'd9:    w_hdr_byte = PROTO_UDP;
      5'd10:   w_hdr_byte = r_csum[15:8];
      5'd11:   w_hdr_byte = r_csum[7:0];
      5'd12:   w_hdr_byte = r_src[31:24];
      5'd13:   w_hdr_byte = r_src[23:16];
      5'd14:   w_hdr_byte = r_src[15:8];
      5'd15:   w_hdr_byte = r_src[7:0];
      5'd16:   w_hdr_byte = r_dst[31:24];
      5'd17:   w_hdr_byte = r_dst[23:16];
      5'd18:   w_hdr_byte = r_dst[15:8];
      5'd19:   w_hdr_byte = r_dst[7:0];
      default: w_hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = 8'h00;
    w_vld_nxt   = 1'b0;
    w_sop_nxt   = 1'b0;
    w_eop_nxt   = 1'b0;
    w_len_pop   = 1'b0;
    w_data_rd   = 1'b0;
    w_ident_inc = 1'b0;
    w_runt_inc  = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_len_empty) begin
        w_len_pop   = 1'b1;
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: w_state_nxt = ST_CSUM;
      ST_CSUM: if (r_runt) begin
        w_runt_inc  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = (r_len == 11'd0) ? ST_IDLE : ST_DROP;
      end else begin
        w_dout_nxt  = VER_IHL;
        w_vld_nxt   = 1'b1;
        w_sop_nxt   = 1'b1;
        w_cnt_nxt   = 11'd1;
        w_state_nxt = ST_HEAD;
      end
      ST_HEAD: begin
        w_dout_nxt = w_hdr_byte;
        w_vld_nxt  = 1'b1;
        // Prefetch the first payload byte so DATA starts without a bubble.
        if (r_cnt == 11'd19) begin
          w_data_rd   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 11'd1;
        end
      end
      ST_DATA: begin
        w_dout_nxt = w_data_rdata;
        w_vld_nxt  = 1'b1;
        if (r_cnt == r_len - 11'd1) begin
          w_eop_nxt   = 1'b1;
          w_ident_inc = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_data_rd = 1'b1;
          w_cnt_nxt = r_cnt + 11'd1;
        end
      end
      ST_DROP: begin
        w_data_rd = 1'b1;
        if (r_cnt == r_len - 11'd1) w_state_nxt = ST_IDLE;
        else                        w_cnt_nxt   = r_cnt + 11'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_pkt    <= 1'b0;
      r_wr_cnt    <= '0;
      r_data_cnt  <= '0;
      r_len_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_runt_cnt  <= '0;
      r_trunc_cnt <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_runt      <= 1'b0;
      r_src       <= '0;
      r_dst       <= '0;
      r_csum      <= '0;
      r_ident     <= '0;
      r_dout      <= '0;
      r_vld       <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
    end else begin
      r_in_pkt   <= w_in_pkt_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_data_cnt <= r_data_cnt + (DAW+1)'(w_data_wr) - (DAW+1)'(w_data_rd_ok);
      r_len_cnt  <= r_len_cnt + (LAW+1)'(w_len_push) - (LAW+1)'(w_len_pop);
      if (w_drop_inc  && (r_drop_cnt  != 8'hFF)) r_drop_cnt  <= r_drop_cnt + 8'd1;
      if (w_trunc_inc && (r_trunc_cnt != 8'hFF)) r_trunc_cnt <= r_trunc_cnt + 8'd1;
      if (w_runt_inc  && (r_runt_cnt  != 8'hFF)) r_runt_cnt  <= r_runt_cnt + 8'd1;
      if (r_state == ST_LOAD) begin
        r_len  <= w_len_rdata.len;
        r_runt <= w_len_rdata.runt;
        r_src  <= src_ip;
        r_dst  <= dst_ip;
      end
      if (r_state == ST_CSUM) r_csum <= ip_csum(w_total_len, r_ident, r_src, r_dst);
      if (w_ident_inc) r_ident <= r_ident + 16'd1;
      r_cnt  <= w_cnt_nxt;
      r_dout <= w_dout_nxt;
      r_vld  <= w_vld_nxt;
      r_sop  <= w_sop_nxt;
      r_eop  <= w_eop_nxt;
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_vld;
  assign dout_sop = r_sop;
  assign dout_eop = r_eop;
  assign status   = {r_drop_cnt, r_runt_cnt, r_trunc_cnt, 5'b0, r_in_pkt, w_len_full, w_data_empty};

endmodule

`default_nettype wire

// File: tb/tb_ipv4_tx_encap.sv
// ============================================================================
// Module : tb_ipv4_tx_encap
// Brief  : Scoreboard bench for ipv4_tx_encap with directed datagrams.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ipv4_tx_encap;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_ip, dst_ip;
  logic [7:0]  din;
  logic        din_vld, din_sop, din_eop;
  logic [7:0]  dout;
  logic        dout_vld, dout_sop, dout_eop;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sop_cyc = -1;
  int eop_out_cyc = -1;
  int last_gap = -1;
  int eop_in_cyc;
  logic [9:0] exp_q [$];
  logic [9:0] mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ipv4_tx_encap dut (
    .clk(clk), .rst(rst), .src_ip(src_ip), .dst_ip(dst_ip),
    .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .status(status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] tl, input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011
      + 32'(src_ip[31:16]) + 32'(src_ip[15:0]) + 32'(dst_ip[31:16]) + 32'(dst_ip[15:0]);
    while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  task automatic expect_pkt(input int len, input logic [7:0] base, input logic [15:0] id,
                            input logic [15:0] cs);
    logic [15:0] tl;
    logic [7:0]  h [20];
    tl = 16'(len + 20);
    h[0] = 8'h45; h[1] = 8'h00; h[2] = tl[15:8]; h[3] = tl[7:0];
    h[4] = id[15:8]; h[5] = id[7:0]; h[6] = 8'h40; h[7] = 8'h00;
    h[8] = 8'h40; h[9] = 8'h11; h[10] = cs[15:8]; h[11] = cs[7:0];
    for (int i = 0; i < 4; i++) begin
      h[12+i] = src_ip[31-8*i -: 8];
      h[16+i] = dst_ip[31-8*i -: 8];
    end
    for (int i = 0; i < 20; i++) exp_q.push_back({h[i], (i == 0), 1'b0});
    for (int i = 0; i < len; i++) exp_q.push_back({8'(base + i), 1'b0, (i == len - 1)});
  endtask

  task automatic send(input int n, input bit with_eop, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      din     = 8'(base + i);
      din_vld = 1'b1;
      din_sop = (i == 0);
      din_eop = with_eop && (i == n - 1);
      @(negedge clk);
    end
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    eop_out_cyc = -1;
    last_gap = -1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  // Monitor: every presented output byte is checked against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (dout_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", dout);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dout_byte", {22'd0, dout_sop, dout_eop, dout}, {22'd0, mon_e[1], mon_e[0], mon_e[9:2]});
        end
        if (dout_sop) begin
          if (eop_out_cyc >= 0) last_gap = cyc - eop_out_cyc - 1;
          sop_cyc = cyc;
        end
        if (dout_eop) eop_out_cyc = cyc;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  adm;
    int  n;
    bit  dropped;
    logic [7:0] b;
    rst = 1'b1;
    din = 8'h00; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    src_ip = 32'hC0A8010A;
    dst_ip = 32'hC0A80164;
    repeat (3) @(negedge clk);
    chk("reset_dout", {24'd0, dout}, 32'd0);
    chk("reset_ctrl", {29'd0, dout_vld, dout_sop, dout_eop}, 32'd0);
    chk("reset_status", status, 32'h0000_0001);
    rst = 1'b0;
    @(negedge clk);

    // Single 12-byte datagram with hand-computed checksum.
    expect_pkt(12, 8'h10, 16'h0000, 16'hB70E);
    send(12, 1'b1, 8'h10);
    eop_in_cyc = cyc;
    wait_drain(200);
    chk("latency_sop", 32'(sop_cyc - eop_in_cyc), 32'd3);

    // Back-to-back pair: ident 1 / checksum B70D and a two-cycle gap.
    do_reset();
    expect_pkt(12, 8'h20, 16'h0000, 16'hB70E);
    expect_pkt(12, 8'h40, 16'h0001, 16'hB70D);
    send(12, 1'b1, 8'h20);
    send(12, 1'b1, 8'h40);
    wait_drain(300);
    chk("gap_cycles", 32'(last_gap), 32'd2);

    // Runt followed by a normal datagram.
    do_reset();
    expect_pkt(12, 8'h60, 16'h0000, 16'hB70E);
    send(5, 1'b1, 8'h50);
    send(12, 1'b1, 8'h60);
    wait_drain(300);
    chk("runt_cnt", {24'd0, status[23:16]}, 32'd1);
    chk("runt_drop_cnt", {24'd0, status[31:24]}, 32'd0);

    // Oversize datagram without eop gets truncated at 1480 bytes.
    do_reset();
    expect_pkt(1480, 8'h00, 16'h0000, model_csum(16'h05DC, 16'h0000));
    send(1500, 1'b0, 8'h00);
    expect_pkt(12, 8'h70, 16'h0001, 16'hB70D);
    send(12, 1'b1, 8'h70);
    wait_drain(4000);
    chk("trunc_cnt", {24'd0, status[15:8]}, 32'd1);
    chk("trunc_in_pkt", {31'd0, status[2]}, 32'd0);

    // Fill the length FIFO with 8-byte datagrams, then one more is dropped.
    do_reset();
    adm = 0;
    dropped = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (status[1]) begin
        send(8, 1'b1, 8'hA0);
        dropped = 1'b1;
        break;
      end
      b = 8'(k * 3);
      expect_pkt(8, b, 16'(adm), model_csum(16'd28, 16'(adm)));
      send(8, 1'b1, b);
      adm++;
    end
    chk("fill_reached_full", {31'd0, dropped}, 32'd1);
    chk("fill_admitted_ge16", {31'd0, (adm >= 16)}, 32'd1);
    wait_drain(3000);
    chk("fill_drop_cnt", {24'd0, status[31:24]}, 32'd1);
    chk("fill_flags_after", {29'd0, status[2:0]}, 32'd1);

    // Reset during header byte 7, then a clean datagram.
    do_reset();
    expect_pkt(12, 8'h80, 16'h0000, 16'hB70E);
    send(12, 1'b1, 8'h80);
    n = 0;
    while (!(dout_vld && dout_sop) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_sop_timeout: got no sop expected sop");
    end
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    chk("midrst_ctrl", {29'd0, dout_vld, dout_sop, dout_eop}, 32'd0);
    chk("midrst_status", status, 32'h0000_0001);
    exp_q.delete();
    eop_out_cyc = -1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_pkt(12, 8'h90, 16'h0000, 16'hB70E);
    send(12, 1'b1, 8'h90);
    wait_drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
